// File: rtl/pc_sequencer.sv
// Program-counter unit: divided step tick, stall, relative branch, absolute jump,
// jump-register and call/return through a circular return-address stack.
module pc_sequencer #(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter int unsigned       RAS_DEPTH = 4,
    parameter int unsigned       TICK_DIV  = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         stall,
    input  logic                         branch,
    input  logic                         zero,
    input  logic                         jump,
    input  logic                         call,
    input  logic                         ret,
    input  logic                         jump_reg,
    input  logic [15:0]                  imm16,
    input  logic [25:0]                  target26,
    input  logic [ADDR_W-1:0]            reg_target,
    output logic [ADDR_W-1:0]            pc,
    output logic                         step,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_overflow,
    output logic                         ras_underflow
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [DIV_W-1:0]  div_q, div_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              step_q, step_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PTR_W-1:0]  sp_q, sp_d, top_idx;
    logic              ovf_q, ovf_d, unf_q, unf_d;
    logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
    logic [ADDR_W-1:0] seq, jtgt, br_tgt;
    logic              tick, push;

    assign tick    = (div_q == DIV_W'(TICK_DIV - 1));
    assign seq     = pc_q + ADDR_W'(1);
    assign br_tgt  = seq + ADDR_W'($signed(imm16));
    assign top_idx = sp_q - PTR_W'(1);

    // Jump target keeps the upper bits of seq only when the PC is wider than the field.
    generate
        if (ADDR_W > 26) begin : g_wide_jtgt
            assign jtgt = {seq[ADDR_W-1:26], target26};
        end else begin : g_narrow_jtgt
            assign jtgt = ADDR_W'(target26);
        end
    endgenerate

    // Next-state: divider always runs; control inputs act only on a non-stalled tick.
    always_comb begin
        div_d  = tick ? '0 : div_q + DIV_W'(1);
        pc_d   = pc_q;
        step_d = 1'b0;
        cnt_d  = cnt_q;
        sp_d   = sp_q;
        ovf_d  = ovf_q;
        unf_d  = unf_q;
        push   = 1'b0;
        if (tick && !stall) begin
            step_d = 1'b1;
            pc_d   = seq;
            if (ret) begin
                if (cnt_q != '0) begin
                    pc_d  = ras_q[top_idx];
                    sp_d  = top_idx;
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    unf_d = 1'b1;
                end
            end else if (jump_reg) begin
                pc_d = reg_target;
            end else if (call) begin
                push = 1'b1;
                pc_d = jtgt;
                sp_d = sp_q + PTR_W'(1);
                // A full stack wraps the pointer and overwrites its oldest entry.
                if (cnt_q == CNT_W'(RAS_DEPTH)) begin
                    ovf_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else if (jump) begin
                pc_d = jtgt;
            end else if (branch && zero) begin
                pc_d = br_tgt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q  <= '0;
            pc_q   <= RESET_VEC;
            step_q <= 1'b0;
            cnt_q  <= '0;
            sp_q   <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            div_q  <= div_d;
            pc_q   <= pc_d;
            step_q <= step_d;
            cnt_q  <= cnt_d;
            sp_q   <= sp_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
        end
    end

    // Stack storage needs no reset; entries are only read while counted valid.
    always_ff @(posedge clk) begin
        if (push) begin
            ras_q[sp_q] <= seq;
        end
    end

    assign pc            = pc_q;
    assign step          = step_q;
    assign ras_count     = cnt_q;
    assign ras_overflow  = ovf_q;
    assign ras_underflow = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a 16-bit single-rate instance driven from a vector
// table, and a 32-bit divide-by-4 instance exercised with hand-written sequences.
module tb_pc_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b;
    logic        stall, branch, zero, jump, call, ret, jump_reg;
    logic [15:0] imm16;
    logic [25:0] target26;
    logic [15:0] rt_a;
    logic [31:0] rt_b;

    logic [15:0] pc_a;
    logic        step_a, ovf_a, unf_a;
    logic [2:0]  cnt_a;
    logic [31:0] pc_b;
    logic        step_b, ovf_b, unf_b;
    logic [2:0]  cnt_b;

    int checks = 0;
    int errors = 0;

    pc_sequencer #(.ADDR_W(16), .RESET_VEC(16'h0010), .RAS_DEPTH(4), .TICK_DIV(1)) u_a (
        .clk(clk), .reset(rst_a), .stall(stall), .branch(branch), .zero(zero),
        .jump(jump), .call(call), .ret(ret), .jump_reg(jump_reg), .imm16(imm16),
        .target26(target26), .reg_target(rt_a), .pc(pc_a), .step(step_a),
        .ras_count(cnt_a), .ras_overflow(ovf_a), .ras_underflow(unf_a)
    );

    pc_sequencer #(.ADDR_W(32), .RESET_VEC(32'h0000_0100), .RAS_DEPTH(4), .TICK_DIV(4)) u_b (
        .clk(clk), .reset(rst_b), .stall(stall), .branch(branch), .zero(zero),
        .jump(jump), .call(call), .ret(ret), .jump_reg(jump_reg), .imm16(imm16),
        .target26(target26), .reg_target(rt_b), .pc(pc_b), .step(step_b),
        .ras_count(cnt_b), .ras_overflow(ovf_b), .ras_underflow(unf_b)
    );

    localparam logic [6:0] NO = 7'h00, ST = 7'h40, BR = 7'h20, ZR = 7'h10;
    localparam logic [6:0] JP = 7'h08, CL = 7'h04, RT = 7'h02, JR = 7'h01;

    typedef struct {
        logic [6:0]  ctl;
        logic [15:0] imm;
        logic [25:0] t26;
        logic [15:0] rtg;
        logic [15:0] e_pc;
        logic        e_step;
        logic [2:0]  e_cnt;
        logic        e_ovf;
        logic        e_unf;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic [6:0] ctl, input logic [15:0] imm,
                                input logic [25:0] t26, input logic [15:0] rtg,
                                input logic [15:0] e_pc, input logic e_step,
                                input logic [2:0] e_cnt, input logic e_ovf, input logic e_unf);
        vec_t v;
        v.ctl = ctl; v.imm = imm; v.t26 = t26; v.rtg = rtg;
        v.e_pc = e_pc; v.e_step = e_step; v.e_cnt = e_cnt; v.e_ovf = e_ovf; v.e_unf = e_unf;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        {stall, branch, zero, jump, call, ret, jump_reg} = 7'h00;
        imm16 = '0; target26 = '0; rt_a = '0; rt_b = '0;
    endtask

    task automatic clocks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        idle_inputs();

        vq.push_back(mk(BR|ZR, 16'hFFFC, 26'h0,    16'h0,    16'h000D, 1, 0, 0, 0));
        vq.push_back(mk(BR,    16'hFFFC, 26'h0,    16'h0,    16'h000E, 1, 0, 0, 0));
        vq.push_back(mk(ST|JP, 16'h0,    26'h99,   16'h0,    16'h000E, 0, 0, 0, 0));
        vq.push_back(mk(ST|JP, 16'h0,    26'h99,   16'h0,    16'h000E, 0, 0, 0, 0));
        vq.push_back(mk(ST|JP, 16'h0,    26'h99,   16'h0,    16'h000E, 0, 0, 0, 0));
        vq.push_back(mk(JR,    16'h0,    26'h0,    16'h0020, 16'h0020, 1, 0, 0, 0));
        vq.push_back(mk(CL,    16'h0,    26'h40,   16'h0,    16'h0040, 1, 1, 0, 0));
        vq.push_back(mk(CL,    16'h0,    26'h80,   16'h0,    16'h0080, 1, 2, 0, 0));
        vq.push_back(mk(RT,    16'h0,    26'h0,    16'h0,    16'h0041, 1, 1, 0, 0));
        vq.push_back(mk(RT,    16'h0,    26'h0,    16'h0,    16'h0021, 1, 0, 0, 0));
        vq.push_back(mk(JR,    16'h0,    26'h0,    16'h0001, 16'h0001, 1, 0, 0, 0));
        vq.push_back(mk(CL,    16'h0,    26'h2,    16'h0,    16'h0002, 1, 1, 0, 0));
        vq.push_back(mk(CL,    16'h0,    26'h3,    16'h0,    16'h0003, 1, 2, 0, 0));
        vq.push_back(mk(CL,    16'h0,    26'h4,    16'h0,    16'h0004, 1, 3, 0, 0));
        vq.push_back(mk(CL,    16'h0,    26'h5,    16'h0,    16'h0005, 1, 4, 0, 0));
        vq.push_back(mk(CL,    16'h0,    26'h6,    16'h0,    16'h0006, 1, 4, 1, 0));
        vq.push_back(mk(RT,    16'h0,    26'h0,    16'h0,    16'h0006, 1, 3, 1, 0));
        vq.push_back(mk(RT,    16'h0,    26'h0,    16'h0,    16'h0005, 1, 2, 1, 0));
        vq.push_back(mk(RT,    16'h0,    26'h0,    16'h0,    16'h0004, 1, 1, 1, 0));
        vq.push_back(mk(RT,    16'h0,    26'h0,    16'h0,    16'h0003, 1, 0, 1, 0));
        vq.push_back(mk(RT,    16'h0,    26'h0,    16'h0,    16'h0004, 1, 0, 1, 1));
        vq.push_back(mk(RT|CL|JP, 16'h0, 26'h77,   16'h0,    16'h0005, 1, 0, 1, 1));
        vq.push_back(mk(JR,    16'h0,    26'h0,    16'hFFFF, 16'hFFFF, 1, 0, 1, 1));
        vq.push_back(mk(NO,    16'h0,    26'h0,    16'h0,    16'h0000, 1, 0, 1, 1));
        vq.push_back(mk(JP,    16'h0,    26'h1234, 16'h0,    16'h1234, 1, 0, 1, 1));
        vq.push_back(mk(BR|ZR, 16'h0010, 26'h0,    16'h0,    16'h1245, 1, 0, 1, 1));
        vq.push_back(mk(JR|CL, 16'h0,    26'h5,    16'h0300, 16'h0300, 1, 0, 1, 1));
        vq.push_back(mk(BR|ZR, 16'h8000, 26'h0,    16'h0,    16'h8301, 1, 0, 1, 1));
        vq.push_back(mk(ST|CL, 16'h0,    26'h9,    16'h0,    16'h8301, 0, 0, 1, 1));

        clocks(3);
        rst_a = 1'b0;
        check("a_rst pc", 32'(pc_a), 32'h10);
        check("a_rst step", 32'(step_a), 32'h0);
        check("a_rst cnt", 32'(cnt_a), 32'h0);
        check("a_rst flags", 32'({ovf_a, unf_a}), 32'h0);

        foreach (vq[i]) begin
            {stall, branch, zero, jump, call, ret, jump_reg} = vq[i].ctl;
            imm16 = vq[i].imm; target26 = vq[i].t26; rt_a = vq[i].rtg;
            clocks(1);
            check($sformatf("v%0d pc", i), 32'(pc_a), 32'(vq[i].e_pc));
            check($sformatf("v%0d step", i), 32'(step_a), 32'(vq[i].e_step));
            check($sformatf("v%0d cnt", i), 32'(cnt_a), 32'(vq[i].e_cnt));
            check($sformatf("v%0d ovf", i), 32'(ovf_a), 32'(vq[i].e_ovf));
            check($sformatf("v%0d unf", i), 32'(unf_a), 32'(vq[i].e_unf));
        end
        idle_inputs();

        // Divide-by-4 instance: PC advances on every 4th clock with a one-cycle step.
        rst_b = 1'b0;
        check("b_rst pc", pc_b, 32'h100);
        check("b_rst step", 32'(step_b), 32'h0);
        for (int k = 1; k <= 12; k++) begin
            clocks(1);
            check($sformatf("div%0d pc", k), pc_b, 32'h100 + 32'(k / 4));
            check($sformatf("div%0d step", k), 32'(step_b), 32'((k % 4) == 0));
        end

        ret = 1'b1;
        clocks(4);
        check("b_unf pc", pc_b, 32'h104);
        check("b_unf flag", 32'(unf_b), 32'h1);
        ret = 1'b0;

        call = 1'b1; target26 = 26'h400;
        clocks(12);
        check("b_call pc", pc_b, 32'h400);
        check("b_call cnt", 32'(cnt_b), 32'h3);
        call = 1'b0;

        jump_reg = 1'b1; rt_b = 32'h0BFF_FFFF;
        clocks(4);
        check("b_jr pc", pc_b, 32'h0BFF_FFFF);
        jump_reg = 1'b0; jump = 1'b1; target26 = 26'h55;
        clocks(4);
        check("b_jhi pc", pc_b, 32'h0C00_0055);
        idle_inputs();

        clocks(2);
        check("b_mid step", 32'(step_b), 32'h0);
        rst_b = 1'b1;
        clocks(1);
        rst_b = 1'b0;
        check("b_mrst pc", pc_b, 32'h100);
        check("b_mrst cnt", 32'(cnt_b), 32'h0);
        check("b_mrst flags", 32'({ovf_b, unf_b}), 32'h0);
        check("b_mrst step", 32'(step_b), 32'h0);
        clocks(3);
        check("b_post3 pc", pc_b, 32'h100);
        clocks(1);
        check("b_post4 pc", pc_b, 32'h101);
        check("b_post4 step", 32'(step_b), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised program-counter unit for the next-generation CPU core. It replaces the fixed 32-bit PC register, the free-running divider and the absolute-only next-PC logic with one block. The block provides a configurable step rate, stall, PC-relative branches, absolute jumps, jump-register, and call/return through a hardware return-address stack (RAS). The core's fetch memory reads `pc`, and the decode/ALU stage drives the control inputs.

Parameters:
- ADDR_W, 32: PC width in bits (word-addressed; sequential step is +1). Legal range 16..32.
- RESET_VEC, 0: PC value loaded on reset.
- RAS_DEPTH, 4: return-address stack entries. Must be a power of 2, at least 2.
- TICK_DIV, 1: the PC advances once every TICK_DIV clocks. 1 means every clock.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold the PC on a step tick.
- branch  in  1  conditional PC-relative branch.
- zero  in  1  ALU zero flag; qualifies `branch`.
- jump  in  1  absolute jump to target26.
- call  in  1  absolute jump to target26 and push the return address.
- ret  in  1  pop the RAS into the PC.
- jump_reg  in  1  jump to reg_target.
- imm16  in  16  branch offset (signed words).
- target26  in  26  jump target field.
- reg_target  in  ADDR_W  register jump target.
- pc  out  ADDR_W  current PC.
- step  out  1  one-cycle pulse in the cycle the PC register updates.
- ras_count  out  $clog2(RAS_DEPTH)+1  number of valid RAS entries.
- ras_overflow  out  1  sticky flag: a push occurred while the RAS was full.
- ras_underflow  out  1  sticky flag: a pop occurred while the RAS was empty.

Behaviour:
- **Reset (synchronous, highest priority):**
  - pc = RESET_VEC, step = 0, divider = 0, ras_count = 0, both flags = 0.
  - Reset mid-operation discards all pending state.
  - RAS entry contents are don't-care after reset.
- **Divider and tick:**
  - The divider counts 0..TICK_DIV-1, then wraps.
  - tick = (divider == TICK_DIV-1). With TICK_DIV = 1, tick is constant 1.
  - The divider runs regardless of `stall`.
- **Stall:**
  - Control inputs are sampled only on a tick cycle.
  - If a tick cycle has stall = 1: pc, RAS and flags hold, and step = 0.
  - The tick is lost; there is no deferred update.
- **Next-PC priority on a non-stalled tick** (seq = pc+1, modulo 2^ADDR_W):
  1. ret: if ras_count > 0, pc <= top entry and ras_count decrements. If ras_count = 0, pc <= seq and ras_underflow <= 1.
  2. jump_reg: pc <= reg_target.
  3. call: push seq, then pc <= J.
  4. jump: pc <= J.
  5. branch & zero: pc <= seq + sign_extend(imm16), truncated to ADDR_W.
  6. otherwise: pc <= seq.
- **Jump target J:** J = {seq[ADDR_W-1:26], target26}. When ADDR_W < 26, J = target26[ADDR_W-1:0].
- **Input conflicts:** only the highest-priority asserted input takes effect. A call that loses priority performs no push.
- **Push when full (ras_count = RAS_DEPTH):**
  - The oldest entry is overwritten (circular buffer).
  - ras_count stays at RAS_DEPTH and ras_overflow <= 1.
  - Later pops return the newest RAS_DEPTH addresses in LIFO order.
- **Outputs and timing:**
  - step = 1 for exactly the one cycle after a non-stalled tick, aligned with the new pc value.
  - pc, step, ras_count and the flags are all registered; no combinational input-to-output path exists.
  - Next-PC latency is 1 clock from a tick.
- **Wrap-around:** seq and branch targets wrap modulo 2^ADDR_W. No error is flagged.
- **Flag clearing:** the flags are sticky and clear only on reset.

Test Plan:
- **Reset, sequential step, divider** (TICK_DIV=4, RESET_VEC=0x100): release reset and idle 12 clocks -> pc becomes 0x101, 0x102, 0x103 on every 4th clock; step pulses 3 times, 1 cycle each.
- **Branch taken and not taken, stall** (TICK_DIV=1): from pc=0x10:
  - branch=1, zero=1, imm16=0xFFFC -> pc=0x0D.
  - branch=1, zero=0 -> pc=0x0E.
  - stall=1 for 3 clocks with jump=1 -> pc stays 0x0E, step=0.
- **Call/return nesting** (RAS_DEPTH=4):
  - At pc=0x20, call target26=0x40 -> pc=0x40, ras_count=1.
  - At 0x40, call 0x80 -> pc=0x80, ras_count=2.
  - ret -> pc=0x41; ret -> pc=0x21; ras_count=0, no flags set.
- **RAS overflow/underflow:** 5 nested calls from pcs 1,2,3,4,5 -> ras_overflow=1, ras_count=4. Then 4 rets return 6,5,4,3. A 5th ret -> pc = previous pc+1 and ras_underflow=1.
- **Priority and wrap** (ADDR_W=16):
  - ret+call+jump together with an empty RAS -> pc=seq, underflow set, no push.
  - jump_reg with reg_target=0xFFFF, then an idle tick -> pc=0x0000.
- **Reset mid-operation:** assert reset while ras_count=3 and divider mid-count -> next clock pc=RESET_VEC, ras_count=0, flags=0, step=0.
